arb_rr_lock: RTL and testbench
==============================

# arb_rr_lock

Round-robin arbiter with per-requester transfer locking, built around the priority to one-hot tree. It registers a one-hot grant and holds it across a multi-beat transfer until the requester's last beat completes. Fairness comes from a rotating mask. It sits between several request sources and one shared downstream port, and drives that port's select and valid.

## Interface
Parameters:
- WIDTH, 8: number of requesters. Must be a power of `SPLIT`.
- SPLIT, 2: tree split factor, passed to both internal priority trees.
- IMPLEMENTATION, 0: priority base-cell implementation, passed to both internal priority trees.
- WIDTH_LOG, $clog2(WIDTH): local parameter, width of `idx`.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- req  input  WIDTH  per-requester request; held high for the whole transfer.
- lst  input  WIDTH  per-requester last-beat flag; sampled only for the granted requester.
- rdy  input  1  downstream ready.
- gnt  output  WIDTH  registered one-hot grant; all zeros when idle.
- idx  output  WIDTH_LOG  binary index of the set `gnt` bit; 0 when idle.
- vld  output  1  grant valid, equal to `|gnt`.
- trn  output  1  transfer strobe, equal to `vld & rdy & |(gnt & req)`.

## Operation
- Two `pry2oht_tree` instances, both with `DIRECTION="LSB"`:
  - Masked tree input: `cnd & msk`.
  - Unmasked tree input: `cnd`.
  - Winner is the masked-tree output if the masked tree's `vld` is set; otherwise the unmasked-tree output.
  - `idx` is the binary encoding of the winner.
- State machine with two states, IDLE and BUSY.
  - IDLE:
    - `cnd = req`.
    - If `|req`, register the winner into `gnt` and go to BUSY.
    - Otherwise stay in IDLE.
  - BUSY:
    - `gnt` holds while `trn` is low, or while `trn` is high and `lst & gnt` is zero.
    - Release happens when `trn` and `|(lst & gnt)` are both high. On release:
      - `msk` becomes the bits strictly above the released index (all zeros if the index is WIDTH-1).
      - `cnd = req & ~gnt`, so the releasing requester is excluded in the release cycle.
      - If `|cnd`, register the new winner into `gnt` and stay in BUSY (back-to-back handover).
      - Otherwise clear `gnt` and go to IDLE.
- `msk` state is WIDTH bits. It changes only on release; when `msk` is all zeros the unmasked tree decides, which gives wrap-around from WIDTH-1 to 0.
- If the granted requester drops `req` while in BUSY, no beat is counted (`trn` is 0) and the grant holds. There is no timeout.
- `lst` bits of non-granted requesters are ignored.
- `req` and `lst` go straight to the combinational trees. There is no input register.

## Timing
- Reset values: `gnt=0`, `idx=0`, `vld=0`, `trn=0`, `msk` all ones (requester 0 has top priority), state IDLE.
- Reset has priority over every other event, including a release in the same cycle.
- From IDLE: `req` seen at edge N gives `gnt` valid after edge N+1. Latency is 1 cycle.
- Handover on release: the new grant is valid on the cycle right after the last beat, with zero bubble cycles.
- A single-beat transfer (`lst` high on the first beat) with `rdy=1` and full contention gives one grant per cycle, rotating.
- `trn` is combinational from `rdy`, `req` and `gnt`. It is not registered.
- Critical path: one priority tree, then the 2:1 winner mux, then the `gnt` register.

## Test plan
- Reset: hold `rst` for 2 cycles with `req=8'hFF` → `gnt=0`, `vld=0`, `idx=0` throughout. Release `rst` → on the next cycle `gnt=8'h01`, `idx=0`.
- Fair rotation: `req=8'hFF`, `lst=8'hFF`, `rdy=1` → `gnt` steps 01, 02, 04, … 80, 01, one per cycle, `trn=1` every cycle.
- Lock:
  - Stimulus: `req=8'h06` from IDLE; `lst[1]` low for 3 beats, then high; `rdy=1`.
  - Response: `gnt=8'h02` for 4 cycles, then `gnt=8'h04` on the next cycle.
- Backpressure and dropped request:
  - While `gnt=8'h04`, drive `rdy=0` for 5 cycles → `gnt` holds, `trn=0`.
  - With `rdy=1`, drop `req[2]` for 2 cycles → `trn=0`, `gnt` holds.
- Wrap and self-exclusion:
  - Last grant was 7, `req=8'h81` at release → next `gnt=8'h01`.
  - Only requester 3 requesting at its release → IDLE for one cycle, then re-granted.
- Reset mid-transfer: `rst` pulsed while `gnt=8'h10` in BUSY → next cycle `gnt=0`, `msk` all ones. The next arbitration grants the lowest active index.

Source files
------------

// File: rtl/arb_rr_lock.sv
// Round-robin arbiter with per-requester transfer locking. The grant is held
// until the owner's last beat completes, then handed over with no bubble.

module pry2oht_tree #(
  parameter int    WIDTH          = 8,
  parameter int    SPLIT          = 2,
  parameter int    IMPLEMENTATION = 0,
  parameter string DIRECTION      = "LSB"
) (
  input  logic [WIDTH-1:0] pry,
  output logic [WIDTH-1:0] oht,
  output logic             vld
);

  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] o;

  // The tree itself always resolves towards bit 0; MSB priority mirrors it.
  if (DIRECTION == "MSB") begin : g_rev
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign p[i]   = pry[WIDTH-1-i];
      assign oht[i] = o[WIDTH-1-i];
    end
  end else begin : g_fwd
    assign p   = pry;
    assign oht = o;
  end

  if (WIDTH <= SPLIT) begin : g_leaf
    assign vld = |p;
    if (IMPLEMENTATION == 0) begin : g_scan
      // NOTE: give o a default before the loop so no path leaves it unassigned
      // (no latch); blocking '=' is correct inside combinational blocks.
      always_comb begin
        o = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
          if (p[i]) o = WIDTH'(1) << i;
        end
      end
    end else begin : g_arith
      assign o = p & (~p + WIDTH'(1));
    end
  end else begin : g_node
    localparam int SUB = WIDTH / SPLIT;

    logic [SPLIT-1:0] sub_vld;
    logic [SPLIT-1:0] sel;
    logic [WIDTH-1:0] sub_oht;
    logic             top_vld;

    for (genvar g = 0; g < SPLIT; g++) begin : g_sub
      pry2oht_tree #(
        .WIDTH          (SUB),
        .SPLIT          (SPLIT),
        .IMPLEMENTATION (IMPLEMENTATION),
        .DIRECTION      ("LSB")
      ) u_sub (
        .pry (p[g*SUB +: SUB]),
        .oht (sub_oht[g*SUB +: SUB]),
        .vld (sub_vld[g])
      );
      assign o[g*SUB +: SUB] = sel[g] ? sub_oht[g*SUB +: SUB] : '0;
    end

    // A second-level tree picks the lowest non-empty group.
    pry2oht_tree #(
      .WIDTH          (SPLIT),
      .SPLIT          (SPLIT),
      .IMPLEMENTATION (IMPLEMENTATION),
      .DIRECTION      ("LSB")
    ) u_top (
      .pry (sub_vld),
      .oht (sel),
      .vld (top_vld)
    );
    assign vld = top_vld;
  end

endmodule

module arb_rr_lock #(
  parameter  int WIDTH          = 8,
  parameter  int SPLIT          = 2,
  parameter  int IMPLEMENTATION = 0,
  localparam int WIDTH_LOG      = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     req,
  input  logic [WIDTH-1:0]     lst,
  input  logic                 rdy,
  output logic [WIDTH-1:0]     gnt,
  output logic [WIDTH_LOG-1:0] idx,
  output logic                 vld,
  output logic                 trn
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state;
  logic [WIDTH-1:0]     msk;
  logic [WIDTH-1:0]     cnd;
  logic [WIDTH-1:0]     arb_msk;
  logic [WIDTH-1:0]     above;
  logic [WIDTH-1:0]     oht_m;
  logic [WIDTH-1:0]     oht_u;
  logic [WIDTH-1:0]     win;
  logic [WIDTH_LOG-1:0] win_idx;
  logic                 vld_m;
  logic                 vld_u;
  logic                 rel;

  assign vld = |gnt;
  assign trn = vld & rdy & |(gnt & req);
  assign rel = (state == BUSY) & trn & |(lst & gnt);

  // Bits strictly above the current owner; empty when the owner is the top bit.
  assign above = ~(gnt | (gnt - WIDTH'(1)));

  // During a release the new mask takes effect in the same cycle, so the
  // handover winner already sees the rotated priority.
  assign cnd     = (state == BUSY) ? (req & ~gnt) : req;
  assign arb_msk = (state == BUSY) ? above : msk;

  pry2oht_tree #(
    .WIDTH          (WIDTH),
    .SPLIT          (SPLIT),
    .IMPLEMENTATION (IMPLEMENTATION),
    .DIRECTION      ("LSB")
  ) u_masked (
    .pry (cnd & arb_msk),
    .oht (oht_m),
    .vld (vld_m)
  );

  pry2oht_tree #(
    .WIDTH          (WIDTH),
    .SPLIT          (SPLIT),
    .IMPLEMENTATION (IMPLEMENTATION),
    .DIRECTION      ("LSB")
  ) u_unmasked (
    .pry (cnd),
    .oht (oht_u),
    .vld (vld_u)
  );

  assign win = vld_m ? oht_m : oht_u;

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (win[i]) win_idx = win_idx | WIDTH_LOG'(i);
    end
  end

  // NOTE: registered state uses non-blocking '<=' so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      idx   <= '0;
      msk   <= '1;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            gnt   <= win;
            idx   <= win_idx;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (rel) begin
            msk <= above;
            if (|cnd) begin
              gnt <= win;
              idx <= win_idx;
            end else begin
              gnt   <= '0;
              idx   <= '0;
              state <= IDLE;
            end
          end
        end
      endcase
    end
  end

  // Unused tree valid of the unmasked instance: any cnd bit implies a winner.
  logic unused_vld_u;
  assign unused_vld_u = vld_u;

endmodule

// File: tb/tb_arb_rr_lock.sv
// Bench for arb_rr_lock: a rotating-search reference model feeds a scoreboard
// of expected grant state, plus directed checks at the interesting cycles.

module tb_arb_rr_lock;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'hFF;
  logic [7:0] lst = 8'h00;
  logic       rdy = 1'b0;
  logic [7:0] gnt;
  logic [2:0] idx;
  logic       vld;
  logic       trn;

  always #5 clk = ~clk;

  arb_rr_lock #(.WIDTH(8), .SPLIT(2), .IMPLEMENTATION(0)) dut (
    .clk (clk),
    .rst (rst),
    .req (req),
    .lst (lst),
    .rdy (rdy),
    .gnt (gnt),
    .idx (idx),
    .vld (vld),
    .trn (trn)
  );

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       vld;
  } exp_t;

  exp_t sb[$];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: last owner index and a search start pointer.
  logic [7:0] m_gnt  = 8'h00;
  int         m_ptr  = 0;
  logic       m_busy = 1'b0;

  function automatic logic [7:0] pick(input logic [7:0] c, input int start);
    int j;
    for (int i = 0; i < 8; i++) begin
      j = (start + i) % 8;
      if (c[j]) return 8'(1) << j;
    end
    return 8'h00;
  endfunction

  function automatic int index_of(input logic [7:0] oh);
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) return i;
    end
    return 0;
  endfunction

  task automatic cycle(input logic r, input logic [7:0] rq, input logic [7:0] ls, input logic rd);
    logic       m_trn;
    logic [7:0] cand;
    exp_t       e;
    exp_t       got;
    @(negedge clk);
    rst = r;
    req = rq;
    lst = ls;
    rdy = rd;
    #1;
    m_trn = (m_gnt != 8'h00) && rd && ((rq & m_gnt) != 8'h00);
    check("trn", trn, m_trn);

    if (r) begin
      m_gnt  = 8'h00;
      m_ptr  = 0;
      m_busy = 1'b0;
    end else if (!m_busy) begin
      if (rq != 8'h00) begin
        m_gnt  = pick(rq, m_ptr);
        m_busy = 1'b1;
      end
    end else if (m_trn && ((ls & m_gnt) != 8'h00)) begin
      m_ptr = (index_of(m_gnt) + 1) % 8;
      cand  = rq & ~m_gnt;
      if (cand != 8'h00) begin
        m_gnt = pick(cand, m_ptr);
      end else begin
        m_gnt  = 8'h00;
        m_busy = 1'b0;
      end
    end
    e.gnt = m_gnt;
    e.idx = 3'(index_of(m_gnt));
    e.vld = (m_gnt != 8'h00);
    sb.push_back(e);

    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      got = sb.pop_front();
      check("gnt", gnt, got.gnt);
      check("idx", idx, got.idx);
      check("vld", vld, got.vld);
    end
  endtask

  initial begin
    // Reset held with full request: no grant may appear.
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 8'hFF, 8'hFF, 1'b1);
      check("rst_gnt", gnt, 8'h00);
    end

    // Fair rotation with single-beat transfers.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 8'hFF, 8'hFF, 1'b1);
      check("rot_gnt", gnt, 32'(8'(1) << (i % 8)));
    end

    // Lock: requester 1 holds for four beats, then hands over to 2.
    cycle(1'b1, 8'h06, 8'h00, 1'b1);
    cycle(1'b0, 8'h06, 8'h00, 1'b1);
    check("lock_first", gnt, 8'h02);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 8'h06, 8'h00, 1'b1);
      check("lock_hold", gnt, 8'h02);
    end
    cycle(1'b0, 8'h06, 8'h02, 1'b1);
    check("lock_handover", gnt, 8'h04);

    // Backpressure, then the owner drops its request.
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 8'h06, 8'hFF, 1'b0);
      check("bp_hold", gnt, 8'h04);
    end
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 8'h02, 8'hFF, 1'b1);
      check("drop_hold", gnt, 8'h04);
    end
    cycle(1'b0, 8'h06, 8'h04, 1'b1);
    check("after_drop", gnt, 8'h02);

    // Wrap from 7 to 0, then self-exclusion through IDLE.
    cycle(1'b0, 8'h82, 8'h02, 1'b1);
    check("to_top", gnt, 8'h80);
    cycle(1'b0, 8'h81, 8'h80, 1'b1);
    check("wrap", gnt, 8'h01);
    cycle(1'b0, 8'h09, 8'h01, 1'b1);
    check("to_three", gnt, 8'h08);
    cycle(1'b0, 8'h08, 8'h08, 1'b1);
    check("self_idle", gnt, 8'h00);
    cycle(1'b0, 8'h08, 8'h00, 1'b1);
    check("regrant", gnt, 8'h08);

    // Reset in the middle of a transfer owned by requester 4.
    cycle(1'b0, 8'h18, 8'h08, 1'b1);
    check("to_four", gnt, 8'h10);
    cycle(1'b1, 8'h18, 8'h00, 1'b1);
    check("rst_mid", gnt, 8'h00);
    cycle(1'b0, 8'h16, 8'h00, 1'b1);
    check("rst_lowest", gnt, 8'h02);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 59) == 0,
            8'($urandom),
            8'($urandom),
            $urandom_range(0, 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
